// File: rtl/adc_osr_pkg.sv
// Shared definitions for the multi-channel SAR result post-processor.
// Holds the default geometry, the per-channel occupancy states, the filter
// mode encoding and a helper that sizes the channel tag.
package adc_osr_pkg;

    localparam int RESULT_BITS_DEF  = 12;
    localparam int MAX_OSR_LOG2_DEF = 7;
    localparam int NUM_CH_DEF       = 4;

    // EMPTY: no partial window / no IIR seed yet.  FILLING: state is live.
    typedef enum logic {
        CH_EMPTY   = 1'b0,
        CH_FILLING = 1'b1
    } ch_state_t;

    typedef enum logic {
        MODE_DECIM = 1'b0,
        MODE_IIR   = 1'b1
    } filt_mode_t;

    // A single channel still needs a 1-bit tag.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_osr_alu.sv
// Combinational next-state datapath shared by all channels.
// Given the (already flush-adjusted) state of the addressed channel and the
// incoming sample, produces the channel's next state, accumulator and
// counter, whether an output is emitted, and the output value.
//   mode       : decimation or IIR
//   osr_mode   : 0 = RESULT_BITS precision, 1 = full OUT_BITS precision
//   k          : window log2 / IIR shift (already clamped)
//   cur_*      : current channel state, accumulator (sum or y), count
//   sample     : raw conversion result
//   next_*     : updated channel state
//   emit       : this sample produces an output
//   out_value  : value to present on the output when emit is set
module adc_osr_alu
    import adc_osr_pkg::*;
#(
    parameter int RESULT_BITS  = RESULT_BITS_DEF,
    parameter int MAX_OSR_LOG2 = MAX_OSR_LOG2_DEF,
    localparam int OUT_BITS    = RESULT_BITS + MAX_OSR_LOG2,
    localparam int CNT_BITS    = MAX_OSR_LOG2 + 1
) (
    input  filt_mode_t             mode,
    input  logic                   osr_mode,
    input  logic [2:0]             k,
    input  ch_state_t              cur_state,
    input  logic [OUT_BITS-1:0]    cur_acc,
    input  logic [CNT_BITS-1:0]    cur_cnt,
    input  logic [RESULT_BITS-1:0] sample,
    output ch_state_t              next_state,
    output logic [OUT_BITS-1:0]    next_acc,
    output logic [CNT_BITS-1:0]    next_cnt,
    output logic                   emit,
    output logic [OUT_BITS-1:0]    out_value
);

    localparam logic [2:0] K_MAX = 3'((MAX_OSR_LOG2 > 7) ? 7 : MAX_OSR_LOG2);

    logic [OUT_BITS-1:0]      sample_ext;
    logic [OUT_BITS-1:0]      x_fix;
    logic [OUT_BITS-1:0]      sum_next;
    logic [CNT_BITS-1:0]      cnt_next;
    logic [CNT_BITS-1:0]      cnt_target;
    logic [2:0]               left_shift;
    logic signed [OUT_BITS:0] diff;
    logic signed [OUT_BITS:0] diff_shifted;
    logic [OUT_BITS-1:0]      y_next;

    always_comb begin
        sample_ext   = OUT_BITS'(sample);
        x_fix        = sample_ext << MAX_OSR_LOG2;
        sum_next     = cur_acc + sample_ext;
        cnt_next     = cur_cnt + CNT_BITS'(1);
        cnt_target   = CNT_BITS'(1) << k;
        left_shift   = K_MAX - k;
        // One extra bit keeps x - y exact before the arithmetic shift.
        diff         = $signed({1'b0, x_fix}) - $signed({1'b0, cur_acc});
        diff_shifted = diff >>> k;
        y_next       = (cur_state == CH_EMPTY) ? x_fix
                                               : cur_acc + diff_shifted[OUT_BITS-1:0];

        next_state = cur_state;
        next_acc   = cur_acc;
        next_cnt   = cur_cnt;
        emit       = 1'b0;
        out_value  = '0;

        if (mode == MODE_IIR) begin
            next_state = CH_FILLING;
            next_acc   = y_next;
            emit       = 1'b1;
            out_value  = osr_mode ? y_next : (y_next >> MAX_OSR_LOG2);
        end else begin
            emit      = (cnt_next == cnt_target);
            out_value = osr_mode ? (sum_next << left_shift) : (sum_next >> k);
            if (emit) begin
                next_state = CH_EMPTY;
                next_acc   = '0;
                next_cnt   = '0;
            end else begin
                next_state = CH_FILLING;
                next_acc   = sum_next;
                next_cnt   = cnt_next;
            end
        end
    end

endmodule

// File: rtl/adc_osr_filter_mc.sv
// Multi-channel post-processor for SAR conversion results: averaging /
// decimation, oversampled sum, or first-order IIR, with independent state
// per channel.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : sample strobe; in_ch / in_result qualify it
//   avg_control  : k (window log2 or IIR shift), clamped to MAX_OSR_LOG2
//   iir_enable   : IIR mode (overrides decimation)
//   osr_mode     : 0 = RESULT_BITS precision, 1 = full OUT_BITS precision
//   flush        : clear all channel state and err_ch
//   out_valid    : one-cycle strobe qualifying out_ch / out_result
//   err_ch       : sticky flag, a sample arrived with an out-of-range channel
module adc_osr_filter_mc
    import adc_osr_pkg::*;
#(
    parameter int RESULT_BITS  = RESULT_BITS_DEF,
    parameter int MAX_OSR_LOG2 = MAX_OSR_LOG2_DEF,
    parameter int NUM_CH       = NUM_CH_DEF,
    localparam int OUT_BITS    = RESULT_BITS + MAX_OSR_LOG2,
    localparam int CH_BITS     = ch_bits(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [CH_BITS-1:0]     in_ch,
    input  logic [RESULT_BITS-1:0] in_result,
    input  logic [2:0]             avg_control,
    input  logic                   iir_enable,
    input  logic                   osr_mode,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [CH_BITS-1:0]     out_ch,
    output logic [OUT_BITS-1:0]    out_result,
    output logic                   err_ch
);

    localparam int         CNT_BITS = MAX_OSR_LOG2 + 1;
    localparam logic [2:0] K_MAX    = 3'((MAX_OSR_LOG2 > 7) ? 7 : MAX_OSR_LOG2);

    // ---------------- configuration and change detect ----------------
    logic [2:0] k_clamped;
    logic [4:0] cfg_now;
    logic [4:0] cfg_reg;
    logic       do_flush;

    assign k_clamped = (avg_control > K_MAX) ? K_MAX : avg_control;
    assign cfg_now   = {k_clamped, iir_enable, osr_mode};
    // Any live change of the filter setup invalidates every partial window.
    assign do_flush  = flush | (cfg_now != cfg_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_reg <= '0;
        end else begin
            cfg_reg <= cfg_now;
        end
    end

    // ---------------- channel decode ----------------
    logic               in_range;
    logic               accept;
    logic               bad_ch;
    logic [CH_BITS-1:0] sel;

    assign in_range = (32'(in_ch) < NUM_CH);
    assign accept   = in_valid & in_range;
    assign bad_ch   = in_valid & ~in_range;
    assign sel      = in_range ? in_ch : '0;

    // ---------------- per-channel state ----------------
    ch_state_t           state_reg [NUM_CH];
    logic [OUT_BITS-1:0] acc_reg   [NUM_CH];
    logic [CNT_BITS-1:0] cnt_reg   [NUM_CH];

    ch_state_t           cur_state;
    logic [OUT_BITS-1:0] cur_acc;
    logic [CNT_BITS-1:0] cur_cnt;
    ch_state_t           state_next;
    logic [OUT_BITS-1:0] acc_next;
    logic [CNT_BITS-1:0] cnt_next;
    logic                emit;
    logic [OUT_BITS-1:0] out_value;
    filt_mode_t          mode;

    // A flush in the same cycle as a sample is applied first, so the sample
    // sees an empty channel and starts a fresh window or seed.
    assign cur_state = do_flush ? CH_EMPTY : state_reg[sel];
    assign cur_acc   = do_flush ? '0       : acc_reg[sel];
    assign cur_cnt   = do_flush ? '0       : cnt_reg[sel];
    assign mode      = iir_enable ? MODE_IIR : MODE_DECIM;

    adc_osr_alu #(
        .RESULT_BITS  (RESULT_BITS),
        .MAX_OSR_LOG2 (MAX_OSR_LOG2)
    ) u_alu (
        .mode       (mode),
        .osr_mode   (osr_mode),
        .k          (k_clamped),
        .cur_state  (cur_state),
        .cur_acc    (cur_acc),
        .cur_cnt    (cur_cnt),
        .sample     (in_result),
        .next_state (state_next),
        .next_acc   (acc_next),
        .next_cnt   (cnt_next),
        .emit       (emit),
        .out_value  (out_value)
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg[gi] <= CH_EMPTY;
                    acc_reg[gi]   <= '0;
                    cnt_reg[gi]   <= '0;
                end else if (accept && (sel == CH_BITS'(gi))) begin
                    state_reg[gi] <= state_next;
                    acc_reg[gi]   <= acc_next;
                    cnt_reg[gi]   <= cnt_next;
                end else if (do_flush) begin
                    state_reg[gi] <= CH_EMPTY;
                    acc_reg[gi]   <= '0;
                    cnt_reg[gi]   <= '0;
                end
            end
        end
    endgenerate

    // ---------------- output and error registers ----------------
    logic                out_valid_reg;
    logic [CH_BITS-1:0]  out_ch_reg;
    logic [OUT_BITS-1:0] out_result_reg;
    logic                err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_ch_reg     <= '0;
            out_result_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            out_valid_reg <= accept & emit;
            if (accept && emit) begin
                out_ch_reg     <= sel;
                out_result_reg <= out_value;
            end
            // Flush clears the flag, but a bad tag in that same cycle re-arms it.
            if (do_flush) begin
                err_reg <= bad_ch;
            end else if (bad_ch) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_ch     = out_ch_reg;
    assign out_result = out_result_reg;
    assign err_ch     = err_reg;

endmodule

// File: tb/tb_adc_osr_filter_mc.sv
// Scoreboard bench for adc_osr_filter_mc (5 channels so that a 3-bit tag can
// carry out-of-range values 5..7).
module tb_adc_osr_filter_mc;

    localparam int RB   = 12;
    localparam int MX   = 7;
    localparam int NUM  = 5;
    localparam int OB   = RB + MX;
    localparam int CHB  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [CHB-1:0] in_ch = '0;
    logic [RB-1:0] in_result = '0;
    logic [2:0]    avg_control = '0;
    logic          iir_enable = 1'b0;
    logic          osr_mode = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [CHB-1:0] out_ch;
    logic [OB-1:0] out_result;
    logic          err_ch;

    adc_osr_filter_mc #(.RESULT_BITS(RB), .MAX_OSR_LOG2(MX), .NUM_CH(NUM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_result(in_result),
        .avg_control(avg_control), .iir_enable(iir_enable), .osr_mode(osr_mode), .flush(flush),
        .out_valid(out_valid), .out_ch(out_ch), .out_result(out_result), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int     cyc;
        int     ch;
        longint val;
    } exp_t;
    exp_t sb[$];

    // Reference model: samples of each open window, IIR state per channel.
    longint win[NUM][$];
    longint y_m[NUM];
    bit     seeded[NUM];
    int     prev_cfg = 0;
    bit     err_exp = 1'b0;

    function automatic void model_clear();
        for (int c = 0; c < NUM; c++) begin
            win[c].delete();
            y_m[c] = 0;
            seeded[c] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit v, input int ch, input int res, input int k,
                                       input bit iir, input bit osr, input bit fl, input int out_cyc);
        int     cfg;
        longint s, v_out, x;
        exp_t   e;
        cfg = k * 4 + int'(iir) * 2 + int'(osr);
        if (fl || cfg != prev_cfg) begin
            model_clear();
            err_exp = 1'b0;
        end
        prev_cfg = cfg;
        if (!v) return;
        if (ch >= NUM) begin
            err_exp = 1'b1;
            return;
        end
        if (iir) begin
            x = longint'(res) * 128;
            if (!seeded[ch]) begin
                y_m[ch] = x;
                seeded[ch] = 1'b1;
            end else begin
                y_m[ch] = y_m[ch] + ((x - y_m[ch]) >>> k);
            end
            v_out = osr ? y_m[ch] : (y_m[ch] / 128);
        end else begin
            win[ch].push_back(longint'(res));
            if (win[ch].size() != (1 << k)) return;
            s = 0;
            foreach (win[ch][i]) s += win[ch][i];
            win[ch].delete();
            v_out = osr ? (s * (1 << (MX - k))) : (s / (1 << k));
        end
        e.cyc = out_cyc;
        e.ch  = ch;
        e.val = v_out;
        sb.push_back(e);
    endfunction

    task automatic drive(input bit v, input int ch, input int res, input int k,
                         input bit iir, input bit osr, input bit fl);
        @(posedge clk);
        #1;
        checks++;
        if (err_ch !== err_exp) begin
            failures++;
            $display("FAIL err_ch cyc=%0d actual=%0b required=%0b", cyc, err_ch, err_exp);
        end
        in_valid    = v;
        in_ch       = CHB'(ch);
        in_result   = RB'(res);
        avg_control = 3'(k);
        iir_enable  = iir;
        osr_mode    = osr;
        flush       = fl;
        model_step(v, ch, res, k, iir, osr, fl, cyc + 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        prev_cfg = 0;
        err_exp = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes out_valid.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_output cyc=%0d required ch=%0d val=%0d", sb[0].cyc, sb[0].ch, sb[0].val);
                void'(sb.pop_front());
            end
            if (!rst && out_valid) begin
                checks++;
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    if (out_ch !== CHB'(sb[0].ch) || out_result !== OB'(sb[0].val)) begin
                        failures++;
                        $display("FAIL output cyc=%0d actual ch=%0d val=%0d required ch=%0d val=%0d",
                                 cyc, out_ch, out_result, sb[0].ch, sb[0].val);
                    end else begin
                        $display("out cyc=%0d ch=%0d val=%0d", cyc, out_ch, out_result);
                    end
                    void'(sb.pop_front());
                end else begin
                    failures++;
                    $display("FAIL unexpected_output cyc=%0d actual ch=%0d val=%0d", cyc, out_ch, out_result);
                end
            end
        end
    end

    initial begin
        int r, ch, k, iir, osr;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid actual=%0b required=0", out_valid); end
        if (out_ch !== '0)       begin failures++; $display("FAIL reset_out_ch actual=%0d required=0", out_ch); end
        if (out_result !== '0)   begin failures++; $display("FAIL reset_out_result actual=%0d required=0", out_result); end
        if (err_ch !== 1'b0)     begin failures++; $display("FAIL reset_err_ch actual=%0b required=0", err_ch); end
        rst = 1'b0;

        // Mean of a 4-window, then left-aligned sum, then pass-through.
        for (int i = 0; i < 4; i++) drive(1, 0, 100 + i, 2, 0, 0, 0);
        drive(0, 0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 100 + i, 2, 0, 1, 0);
        drive(0, 0, 0, 2, 0, 1, 0);
        drive(1, 1, 7, 0, 0, 0, 0);
        drive(1, 1, 4095, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 2, 4095, 0, 0, 1, 0);

        // Interleaved channels at full scale and zero.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4095, 2, 0, 0, 0);
            drive(1, 3, 0, 2, 0, 0, 0);
        end

        // IIR seed then two steps: 0, 500, 750.
        drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 1, 1000, 1, 1, 0, 0);
        drive(1, 1, 1000, 1, 1, 0, 0);
        drive(1, 1, 3000, 3, 1, 1, 0);
        drive(1, 1, 100, 3, 1, 1, 0);

        // Config change mid-window discards the partial window.
        drive(1, 0, 4000, 2, 0, 0, 0);
        drive(1, 0, 4000, 2, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 10 * i + 3, 3, 0, 0, 0);

        // Out-of-range tag, then flush together with a sample on ch2.
        drive(1, 5, 123, 2, 0, 0, 0);
        drive(0, 0, 0, 2, 0, 0, 0);
        drive(1, 2, 40, 2, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 2, 41 + i, 2, 0, 0, 0);
        drive(1, 7, 1, 2, 0, 0, 1);
        drive(0, 0, 0, 2, 0, 0, 0);

        // Reset mid-window.
        drive(1, 0, 2000, 2, 0, 0, 0);
        drive(1, 0, 2000, 2, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 8 + i, 2, 0, 0, 0);

        // Randomised traffic with occasional config changes and flushes.
        k = 2; iir = 0; osr = 0;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 4) begin
                k = int'($urandom_range(0, 7));
                if (k > 4 && $urandom_range(0, 1) == 1) k = int'($urandom_range(0, 3));
                iir = int'($urandom_range(0, 1));
                osr = int'($urandom_range(0, 1));
            end
            ch = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            drive($urandom_range(0, 9) < 7, ch, int'($urandom_range(0, 4095)), k, iir[0], osr[0],
                  $urandom_range(0, 149) == 0);
        end
        drive(0, 0, 0, k, iir[0], osr[0], 0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
